// File: rtl/sample_ram_pkg.sv
// Shared constants and reader state encoding for the scope sample RAM.
package sample_ram_pkg;

  localparam int unsigned ADDR_W         = 10;
  localparam int unsigned DATA_W         = 560;
  localparam int unsigned DEPTH          = 2 ** ADDR_W;
  localparam int unsigned OUT_W          = 8;
  localparam int unsigned CNT_W          = ADDR_W + 1;
  localparam int unsigned BEATS_PER_WORD = DATA_W / OUT_W;
  localparam int unsigned BEAT_W         = $clog2(BEATS_PER_WORD);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StSend,
    StFin
  } reader_state_e;

endpackage

// File: rtl/sample_word_serializer.sv
// Parallel-load shift register that emits one RAM word as LSB-first beats on a
// valid/ready stream.
module sample_word_serializer
  import sample_ram_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              clear_i,
  input  logic              last_word_i,
  input  logic              out_ready_i,
  output logic [OUT_W-1:0]  out_data_o,
  output logic              out_valid_o,
  output logic              out_last_o,
  output logic              word_done_o
);

  localparam logic [BEAT_W-1:0] LastBeat = BEAT_W'(BEATS_PER_WORD - 1);

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              valid_q, valid_d;
  logic              last_beat;
  logic              accept;

  assign last_beat = (beat_q == LastBeat);
  assign accept    = valid_q && out_ready_i;

  // Next state: clear beats load beats shift on handshake.
  always_comb begin
    shift_d = shift_q;
    beat_d  = beat_q;
    valid_d = valid_q;
    if (clear_i) begin
      shift_d = '0;
      beat_d  = '0;
      valid_d = 1'b0;
    end else if (load_i) begin
      shift_d = load_data_i;
      beat_d  = '0;
      valid_d = 1'b1;
    end else if (accept) begin
      shift_d = shift_q >> OUT_W;
      if (last_beat) begin
        beat_d  = '0;
        valid_d = 1'b0;
      end else begin
        beat_d = beat_q + BEAT_W'(1);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q <= '0;
      beat_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
    end
  end

  assign out_data_o  = shift_q[OUT_W-1:0];
  assign out_valid_o = valid_q;
  assign out_last_o  = valid_q && last_word_i && last_beat;
  assign word_done_o = accept && last_beat;

endmodule

// File: rtl/sample_ram_reader.sv
// Read-side engine: walks a circular window of the sample RAM and streams each
// word out as OUT_W-bit beats.
module sample_ram_reader
  import sample_ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  num_words,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0] MaxWords = CNT_W'(DEPTH);

  reader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic              load;
  logic              clear;
  logic              word_done;

  // FSM next state: addressing, word counting and abort handling.
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    remaining_d = remaining_q;
    load        = 1'b0;
    clear       = 1'b0;
    if (abort && (state_q != StIdle)) begin
      state_d     = StIdle;
      remaining_d = '0;
      clear       = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && !abort) begin
            if (num_words == '0) begin
              state_d = StFin;
            end else begin
              remaining_d = (num_words > MaxWords) ? MaxWords : num_words;
              rd_addr_d   = start_addr;
              state_d     = StFetch;
            end
          end
        end
        StFetch: state_d = StWait;
        StWait: begin
          // rd_data is valid now; the serializer captures it on this edge.
          load        = 1'b1;
          remaining_d = remaining_q - CNT_W'(1);
          rd_addr_d   = rd_addr_q + ADDR_W'(1);
          state_d     = StSend;
        end
        StSend: begin
          if (word_done) begin
            state_d = (remaining_q != '0) ? StFetch : StFin;
          end
        end
        StFin:   state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rd_addr_q   <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      remaining_q <= remaining_d;
    end
  end

  sample_word_serializer u_serializer (
    .clk_i       (clk),
    .rst_i       (rst),
    .load_i      (load),
    .load_data_i (rd_data),
    .clear_i     (clear),
    .last_word_i (remaining_q == '0),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_last_o  (out_last),
    .word_done_o (word_done)
  );

  assign rd_addr = rd_addr_q;
  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StFin);

endmodule
